// File: rtl/pid_ctrl_pkg.sv
// Shared definitions for the motor position PID controller: operating
// modes, computation state encoding and the fixed result latency.
package pid_ctrl_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_BIAS  = 2'd1;
  localparam logic [1:0] MODE_CLOSE = 2'd2;
  localparam logic [1:0] MODE_CALI  = 2'd3;

  // Cycles from an accepted measurement strobe to the output strobe.
  localparam int PID_LAT = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_MP   = 3'd2,
    S_MI   = 3'd3,
    S_MD   = 3'd4,
    S_SAT  = 3'd5
  } pid_state_e;

endpackage

// File: rtl/pid_ctrl_core_trig.sv
// Free-running period counter producing the one-cycle motor read trigger.
// The next-cycle trigger value is exported so the core can register its
// open-loop output strobe on the same edge as the trigger itself.
module pid_trig_gen #(
  parameter int PW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [PW-1:0] period_i,
  output logic          trig_o,
  output logic          trig_next_o
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          trig_q, trig_d;

  // Next count: a zero period parks the counter; reaching the period wraps
  // to zero and fires the trigger. Using >= lets a shortened period take
  // effect at the very next compare instead of waiting for a full rollover.
  always_comb begin
    cnt_d  = cnt_q + {{(PW-1){1'b0}}, 1'b1};
    trig_d = 1'b0;
    if (period_i == '0) begin
      cnt_d = '0;
    end else if (cnt_q >= period_i) begin
      cnt_d  = '0;
      trig_d = 1'b1;
    end
  end

  // Counter and trigger registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
    end
  end

  assign trig_o      = trig_q;
  assign trig_next_o = trig_d;

endmodule

// File: rtl/pid_ctrl_core.sv
// Motor position PID controller: positional P+I+D through one shared
// multiplier, output offset, saturation with conditional-integration
// anti-windup, open-loop bias/calibration modes and the read trigger.
module pid_ctrl_core
  import pid_ctrl_pkg::*;
#(
  parameter int DW    = 24,
  parameter int GW    = 23,
  parameter int IW    = 32,
  parameter int SHIFT = 16,
  parameter int OW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [1:0]    mode_i,
  input  logic [31:0]   period_i,
  input  logic [GW-1:0] kp_i,
  input  logic [GW-1:0] ki_i,
  input  logic [GW-1:0] kd_i,
  input  logic [IW-2:0] int_lim_i,
  input  logic [DW-1:0] position_aim_i,
  input  logic          meas_vld_i,
  input  logic [DW-1:0] meas_data_i,
  input  logic [OW-1:0] bias_i,
  input  logic [OW-1:0] cali_i,
  output logic          rd_trig_o,
  output logic          out_vld_o,
  output logic [OW-1:0] out_data_o,
  output logic          sat_o,
  output logic          ovr_o,
  output logic          busy_o
);

  localparam int EW   = DW + 1;
  localparam int DEW  = DW + 2;
  localparam int PW   = GW + 1 + IW;
  localparam int ACCW = IW + GW + 2;

  pid_state_e              state_q;
  logic signed [EW-1:0]    err_q, ePrev_q;
  logic signed [DEW-1:0]   de_q;
  logic signed [IW-1:0]    integ_q, integNew_q;
  logic signed [ACCW-1:0]  acc_q;
  logic                    first_q, done_q;
  logic                    outVld_q, sat_q;
  logic [OW-1:0]           outData_q;

  logic                    trigNext;
  logic signed [EW-1:0]    err_d;
  logic signed [DEW-1:0]   de_d;
  logic signed [IW:0]      integSum, limPos, limNeg;
  logic signed [IW-1:0]    integNew_d;
  logic [GW-1:0]           mulGain;
  logic signed [IW-1:0]    mulOpnd;
  logic signed [PW-1:0]    product;
  logic signed [ACCW-1:0]  productExt, accShift;
  logic [ACCW:0]           uSum;
  logic                    satHigh, satLow, errPos, errNeg;

  pid_trig_gen #(.PW(32)) u_trig (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .period_i    (period_i),
    .trig_o      (rd_trig_o),
    .trig_next_o (trigNext)
  );

  // Error, derivative and the clamped integrator candidate. The sum is one
  // bit wider than the integrator, and since the limit is below 2^(IW-1)
  // the clamp also keeps the result inside IW bits.
  always_comb begin
    err_d    = $signed({position_aim_i[DW-1], position_aim_i})
             - $signed({meas_data_i[DW-1], meas_data_i});
    de_d     = first_q ? '0
             : $signed({err_q[EW-1], err_q}) - $signed({ePrev_q[EW-1], ePrev_q});
    integSum = $signed({integ_q[IW-1], integ_q})
             + $signed({{(IW+1-EW){err_q[EW-1]}}, err_q});
    limPos   = $signed({2'b00, int_lim_i});
    limNeg   = -limPos;
    if (integSum > limPos) begin
      integNew_d = limPos[IW-1:0];
    end else if (integSum < limNeg) begin
      integNew_d = limNeg[IW-1:0];
    end else begin
      integNew_d = integSum[IW-1:0];
    end
  end

  // Shared multiplier: the state selects which gain and operand feed it, so
  // each gain is sampled only in the cycle its term is accumulated.
  always_comb begin
    mulGain = kp_i;
    mulOpnd = $signed({{(IW-EW){err_q[EW-1]}}, err_q});
    case (state_q)
      S_MI: begin
        mulGain = ki_i;
        mulOpnd = integNew_q;
      end
      S_MD: begin
        mulGain = kd_i;
        mulOpnd = $signed({{(IW-DEW){de_q[DEW-1]}}, de_q});
      end
      default: ;
    endcase
    product    = $signed({1'b0, mulGain}) * mulOpnd;
    productExt = $signed({product[PW-1], product});
  end

  // Scale, offset and range check of the finished sum. The sum is treated
  // as two's complement: sign bit set means below zero, any set bit above
  // the output width means above full scale.
  always_comb begin
    accShift = acc_q >>> SHIFT;
    uSum     = {accShift[ACCW-1], accShift} + {{(ACCW+1-OW){1'b0}}, bias_i};
    satLow   = uSum[ACCW];
    satHigh  = !uSum[ACCW] && (|uSum[ACCW-1:OW]);
    errNeg   = err_q[EW-1];
    errPos   = !err_q[EW-1] && (err_q != '0);
  end

  // Main controller: mode handling and the closed-loop computation FSM.
  // Leaving closed loop aborts any computation in flight without a strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      err_q      <= '0;
      ePrev_q    <= '0;
      de_q       <= '0;
      integ_q    <= '0;
      integNew_q <= '0;
      acc_q      <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      outVld_q   <= 1'b0;
      sat_q      <= 1'b0;
      outData_q  <= '0;
    end else begin
      outVld_q <= 1'b0;
      done_q   <= 1'b0;
      case (mode_i)
        MODE_IDLE: begin
          state_q <= S_IDLE;
          integ_q <= '0;
          ePrev_q <= '0;
          sat_q   <= 1'b0;
          first_q <= 1'b1;
        end
        MODE_BIAS, MODE_CALI: begin
          state_q   <= S_IDLE;
          outData_q <= (mode_i == MODE_BIAS) ? bias_i : cali_i;
          outVld_q  <= trigNext;
          integ_q   <= '0;
          first_q   <= 1'b1;
        end
        default: begin
          case (state_q)
            S_IDLE: begin
              if (meas_vld_i) begin
                err_q   <= err_d;
                state_q <= S_ERR;
              end
            end
            S_ERR: begin
              de_q       <= de_d;
              integNew_q <= integNew_d;
              ePrev_q    <= err_q;
              first_q    <= 1'b0;
              state_q    <= S_MP;
            end
            S_MP: begin
              acc_q   <= productExt;
              state_q <= S_MI;
            end
            S_MI: begin
              acc_q   <= acc_q + productExt;
              state_q <= S_MD;
            end
            S_MD: begin
              acc_q   <= acc_q + productExt;
              state_q <= S_SAT;
            end
            S_SAT: begin
              if (satLow) begin
                outData_q <= '0;
                sat_q     <= 1'b1;
              end else if (satHigh) begin
                outData_q <= '1;
                sat_q     <= 1'b1;
              end else begin
                outData_q <= uSum[OW-1:0];
                sat_q     <= 1'b0;
              end
              if (!((satHigh && errPos) || (satLow && errNeg))) begin
                integ_q <= integNew_q;
              end
              outVld_q <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  assign out_vld_o  = outVld_q;
  assign out_data_o = outData_q;
  assign sat_o      = sat_q;
  assign busy_o     = (state_q != S_IDLE) || done_q;
  assign ovr_o      = (mode_i == MODE_CLOSE) && meas_vld_i && (state_q != S_IDLE);

endmodule

// File: tb/tb_pid_ctrl_core.sv
// Directed self-checking bench for pid_ctrl_core with hand-computed results.
module tb_pid_ctrl_core;
  import pid_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  mode_i;
  logic [31:0] period_i;
  logic [22:0] kp_i, ki_i, kd_i;
  logic [30:0] int_lim_i;
  logic [23:0] position_aim_i;
  logic        meas_vld_i;
  logic [23:0] meas_data_i;
  logic [15:0] bias_i, cali_i;
  logic        rd_trig_o, out_vld_o, sat_o, ovr_o, busy_o;
  logic [15:0] out_data_o;

  int checks = 0;
  int errors = 0;

  pid_ctrl_core #(.DW(24), .GW(23), .IW(32), .SHIFT(16), .OW(16)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .mode_i         (mode_i),
    .period_i       (period_i),
    .kp_i           (kp_i),
    .ki_i           (ki_i),
    .kd_i           (kd_i),
    .int_lim_i      (int_lim_i),
    .position_aim_i (position_aim_i),
    .meas_vld_i     (meas_vld_i),
    .meas_data_i    (meas_data_i),
    .bias_i         (bias_i),
    .cali_i         (cali_i),
    .rd_trig_o      (rd_trig_o),
    .out_vld_o      (out_vld_o),
    .out_data_o     (out_data_o),
    .sat_o          (sat_o),
    .ovr_o          (ovr_o),
    .busy_o         (busy_o)
  );

  // 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  // Passing through mode 0 clears the integrator and rearms the first flag.
  task automatic restartLoop();
    @(negedge clk_i);
    mode_i = MODE_IDLE;
    waitCycles(2);
    mode_i = MODE_CLOSE;
  endtask

  // One closed-loop sample: strobe a measurement and wait (bounded) for the
  // output strobe, returning its data, saturation flag and latency.
  task automatic applyStimulus(input logic [23:0] aim, input logic [23:0] meas,
                               output logic [15:0] data, output logic sat, output int lat);
    @(negedge clk_i);
    position_aim_i = aim;
    meas_data_i    = meas;
    meas_vld_i     = 1'b1;
    @(negedge clk_i);
    meas_vld_i = 1'b0;
    lat = 1;
    while (!out_vld_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    data = out_data_o;
    sat  = sat_o;
  endtask

  initial begin
    logic [15:0] d;
    logic        s;
    int          lat, vldCount, gap;

    rst_n_i = 1'b0; mode_i = MODE_IDLE; period_i = 32'd0;
    kp_i = '0; ki_i = '0; kd_i = '0; int_lim_i = 31'h4000_0000;
    position_aim_i = '0; meas_vld_i = 1'b0; meas_data_i = '0;
    bias_i = 16'h8000; cali_i = '0;

    // Reset state
    waitCycles(3);
    checkOutput("rst_data", out_data_o, 0);
    checkOutput("rst_vld",  out_vld_o, 0);
    checkOutput("rst_flags", {rd_trig_o, sat_o, ovr_o, busy_o}, 0);
    rst_n_i = 1'b1;
    waitCycles(2);

    // Proportional only
    $display("[TB] proportional");
    kp_i = 23'h10000;
    restartLoop();
    applyStimulus(24'd1000, 24'd400, d, s, lat);
    checkOutput("p_lat",  lat, PID_LAT);
    checkOutput("p_data", d, 16'h8258);
    checkOutput("p_sat",  s, 0);

    // Saturation high with anti-windup over three samples
    $display("[TB] saturation");
    ki_i = 23'h10000;
    restartLoop();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(24'd100000, 24'd0, d, s, lat);
      checkOutput($sformatf("sath_data%0d", i), d, 16'hFFFF);
      checkOutput($sformatf("sath_sat%0d", i), s, 1);
    end
    applyStimulus(24'd0, 24'd0, d, s, lat);
    checkOutput("windup_data", d, 16'h8000);
    checkOutput("windup_sat",  s, 0);
    applyStimulus(24'd0, 24'd100000, d, s, lat);
    checkOutput("satl_data", d, 16'h0000);
    checkOutput("satl_sat",  s, 1);

    // Integrator clamp at +25
    $display("[TB] integrator clamp");
    kp_i = '0; kd_i = '0; ki_i = 23'h10000; int_lim_i = 31'd25;
    restartLoop();
    applyStimulus(24'd10, 24'd0, d, s, lat); checkOutput("clamp0", d, 16'h800A);
    applyStimulus(24'd10, 24'd0, d, s, lat); checkOutput("clamp1", d, 16'h8014);
    applyStimulus(24'd10, 24'd0, d, s, lat); checkOutput("clamp2", d, 16'h8019);
    applyStimulus(24'd10, 24'd0, d, s, lat); checkOutput("clamp3", d, 16'h8019);
    int_lim_i = 31'h4000_0000;

    // Derivative and first-sample handling
    $display("[TB] derivative");
    ki_i = '0; kd_i = 23'h10000;
    restartLoop();
    applyStimulus(24'd10, 24'd0, d, s, lat); checkOutput("d_first", d, 16'h8000);
    applyStimulus(24'd30, 24'd0, d, s, lat); checkOutput("d_delta", d, 16'h8014);
    restartLoop();
    applyStimulus(24'd50, 24'd0, d, s, lat); checkOutput("d_rearm", d, 16'h8000);

    // Overrun: second strobe at cycle 3 is dropped
    $display("[TB] overrun");
    kd_i = '0; kp_i = 23'h10000;
    restartLoop();
    @(negedge clk_i);
    position_aim_i = 24'd1000; meas_data_i = 24'd400; meas_vld_i = 1'b1;
    vldCount = 0; d = '0; lat = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_i);
      meas_vld_i  = (c == 3);
      meas_data_i = 24'd0;
      #1;
      if (c == 1) checkOutput("ovr_busy_c1", busy_o, 1);
      if (c == 2) checkOutput("ovr_none_c2", ovr_o, 0);
      if (c == 3) checkOutput("ovr_pulse_c3", ovr_o, 1);
      if (c == 4) checkOutput("ovr_none_c4", ovr_o, 0);
      if (out_vld_o) begin
        vldCount++;
        d   = out_data_o;
        lat = c;
        checkOutput("ovr_busy_vld", busy_o, 1);
      end
    end
    meas_vld_i = 1'b0;
    checkOutput("ovr_count", vldCount, 1);
    checkOutput("ovr_lat",   lat, PID_LAT);
    checkOutput("ovr_data",  d, 16'h8258);

    // Bias mode with a 10-cycle trigger
    $display("[TB] bias and calibration modes");
    @(negedge clk_i);
    mode_i = MODE_BIAS; period_i = 32'd9; bias_i = 16'h1234;
    gap = 0;
    @(negedge clk_i);
    while (!rd_trig_o && gap < 30) begin @(negedge clk_i); gap++; end
    checkOutput("bias_trig_seen", rd_trig_o, 1);
    checkOutput("bias_vld", out_vld_o, 1);
    checkOutput("bias_data", out_data_o, 16'h1234);
    @(negedge clk_i);
    checkOutput("bias_vld_off", {rd_trig_o, out_vld_o}, 0);
    gap = 1;
    while (!rd_trig_o && gap < 30) begin @(negedge clk_i); gap++; end
    checkOutput("bias_period", gap, 10);
    checkOutput("bias_vld2", out_vld_o, 1);

    mode_i = MODE_CALI; cali_i = 16'h0ABC;
    waitCycles(2);
    checkOutput("cali_data", out_data_o, 16'h0ABC);
    gap = 0;
    while (!rd_trig_o && gap < 30) begin @(negedge clk_i); gap++; end
    checkOutput("cali_vld", out_vld_o, 1);

    // Reset asserted during S_MI aborts the sample
    $display("[TB] reset mid-computation");
    period_i = 32'd0;
    @(negedge clk_i);
    mode_i = MODE_CLOSE;
    @(negedge clk_i);
    position_aim_i = 24'd1000; meas_data_i = 24'd400; meas_vld_i = 1'b1;
    @(negedge clk_i);
    meas_vld_i = 1'b0;
    waitCycles(2);
    #1 rst_n_i = 1'b0;
    #1;
    checkOutput("arst_data", out_data_o, 0);
    checkOutput("arst_flags", {rd_trig_o, out_vld_o, sat_o, ovr_o, busy_o}, 0);
    waitCycles(2);
    rst_n_i = 1'b1;
    vldCount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (out_vld_o) vldCount++;
    end
    checkOutput("arst_novld", vldCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_ctrl_core.md
Name: pid_ctrl_core

Overview:
- Parametrised next-generation motor position PID controller for the motor loop. It takes a signed position measurement per sample and computes positional P + I + D with one shared sequential multiplier.
- Applies output offset, saturation and conditional-integration anti-windup, and produces an unsigned DAC code for the motor driver.
- Also generates the programmable motor read trigger and the open-loop bias and calibration modes.

Parameters:
- DW, 24, width of position aim/measurement (signed).
- GW, 23, width of kp/ki/kd gains (unsigned, Q(GW-SHIFT).SHIFT).
- IW, 32, integrator width (signed).
- SHIFT, 16, fractional bits removed from the MAC sum.
- OW, 16, output code width (unsigned).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous reset, active low.
- mode_i  in  2  0 idle, 1 bias, 2 closed loop, 3 calibration.
- period_i  in  32  trigger period minus one; 0 disables the trigger.
- kp_i / ki_i / kd_i  in  GW each  gains.
- int_lim_i  in  IW-1  positive integrator limit; the clamp is ±int_lim_i.
- position_aim_i  in  DW  signed setpoint.
- meas_vld_i  in  1  measurement strobe.
- meas_data_i  in  DW  signed measured position.
- bias_i  in  OW  offset code (closed loop) / open-loop code (mode 1).
- cali_i  in  OW  calibration code (mode 3).
- rd_trig_o  out  1  one-cycle motor read trigger.
- out_vld_o  out  1  one-cycle output strobe.
- out_data_o  out  OW  DAC code.
- sat_o  out  1  last closed-loop output was clipped.
- ovr_o  out  1  pulse: measurement dropped because the core was busy.
- busy_o  out  1  closed-loop computation in flight.

Behaviour:
- Reset: every output is 0; integrator, e_prev, counter and first-flag are cleared; FSM goes to S_IDLE. Reset applies immediately, including mid-computation; no out_vld_o is issued for the aborted sample.
- Trigger counter:
  - Counts 0..period_i; rd_trig_o=1 for the cycle the count wraps from period_i to 0. This gives a period of period_i+1 cycles.
  - period_i==0 holds the counter at 0 and rd_trig_o at 0.
  - A change of period_i takes effect at the next compare.
  - The counter runs in all modes.
- Mode 0: out_vld_o=0; out_data_o holds its value; integrator, e_prev and sat_o are cleared; first-flag is set.
- Modes 1 and 3:
  - out_data_o <= bias_i (mode 1) or cali_i (mode 3) every cycle.
  - out_vld_o is registered coincident with rd_trig_o.
  - Integrator is cleared, first-flag is set, and meas_vld_i is ignored.
- Mode 2 FSM, one state per cycle; the accepted meas_vld_i is at cycle 0:
  - S_IDLE, when meas_vld_i=1: e <= aim - meas (DW+1 bits, sign-extended). Go to S_ERR.
  - S_ERR:
    - de <= first ? 0 : e - e_prev (DW+2 bits).
    - integ_new <= clamp(integ + e, -int_lim_i, +int_lim_i), saturating at IW.
    - e_prev <= e; first <= 0.
  - S_MP: acc <= kp*e.
  - S_MI: acc <= acc + ki*integ_new.
  - S_MD: acc <= acc + kd*de. The accumulator is IW+GW+2 bits, signed, and never wraps.
  - S_SAT:
    - u = (acc >>> SHIFT, arithmetic) + bias_i.
    - u<0 gives 0 with sat_o=1; u>2^OW-1 gives 2^OW-1 with sat_o=1; otherwise u with sat_o=0.
    - Anti-windup: if clipped high with e>0, or clipped low with e<0, integ keeps its pre-sample value; otherwise integ <= integ_new.
    - Register out_data_o and set out_vld_o=1 at cycle 6. Return to S_IDLE.
- Fixed latency: out_vld_o appears 6 cycles after the accepted meas_vld_i. busy_o=1 in cycles 1..6, i.e. from S_ERR through the out_vld_o cycle. meas_vld_i is accepted again from cycle 6.
- meas_vld_i while busy_o=1: the sample is dropped, ovr_o pulses for 1 cycle, and state is unchanged.
- A mode change away from 2 during a computation aborts to S_IDLE with no out_vld_o; the new mode's rules apply from the next cycle.
- Gains and aim are sampled in the state that uses them. Software changes them only while the loop is in mode 0/1.

Decomposition:
- Shared package pid_ctrl_pkg holds:
  - Mode constants MODE_IDLE/BIAS/CLOSE/CALI.
  - The state encoding S_IDLE..S_SAT.
  - The latency constant PID_LAT=6.
- One sub-module: pid_trig_gen, containing the period counter and rd_trig_o.
- The multiplier is inferred (DSP), not an IP core.

Test Plan (DW=24, SHIFT=16, OW=16):
- Proportional: mode 2, kp=0x10000, ki=kd=0, aim=1000, meas=400, bias=0x8000 -> out_vld_o 6 cycles later, out_data_o=0x8258, sat_o=0.
- Saturation and anti-windup: kp=0x10000, ki=0x10000, aim=100000, meas=0, bias=0x8000 -> 0xFFFF with sat_o=1; the integrator stays 0 across 3 samples. With aim=0, meas=100000 the output is 0x0000 with sat_o=1.
- Integrator clamp: kp=kd=0, ki=0x10000, e=10 for 4 samples, int_lim=25 -> outputs bias+10, +20, +25, +25.
- Derivative and first-flag: kd=0x10000 only, e=10 then 30 -> bias+0, then bias+20. Switch to mode 0 and back, then e=50 -> bias+0.
- Overrun: a second meas_vld_i at cycle 3 -> ovr_o pulses at cycle 3, exactly one out_vld_o, and the result equals the first sample only.
- Modes and reset: mode 1, period_i=9, bias=0x1234 -> rd_trig_o and out_vld_o every 10 cycles with data 0x1234. Mode 3, cali=0x0ABC -> 0x0ABC. rst_n_i low during S_MI -> all outputs 0 and no out_vld_o.
